// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: default constants,
// FSM state encoding and buffer geometry.
package instr_fetch_pkg;

  localparam logic [31:0] IF_NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] IF_RESET_PC   = 32'h0000_0000;
  localparam int          IF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_buf.sv
// fetch_buf: 2-entry synchronous FIFO of {instr, pc} words with flush.
// Active-low synchronous reset on control state; flush beats push.
module fetch_buf
  import instr_fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [2*XLEN-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [2*XLEN-1:0] head,
  output logic [1:0]        count
);

  logic [2*XLEN-1:0] mem_q [IF_FIFO_DEPTH];
  logic [2*XLEN-1:0] mem_d [IF_FIFO_DEPTH];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              pop_eff, push_eff;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // A pop on an empty buffer is ignored; a full buffer accepts a push only alongside a pop.
    pop_eff  = pop & (count_q != 2'd0);
    push_eff = push & ((count_q != 2'd2) | pop_eff);
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_eff) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_eff) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push_eff) - 2'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, 1-cycle-latency imem requests, 2-deep {instr,pc}
// buffer toward cu, redirect/squash. IF_MISALIGN_TRAP_EN adds the FAULT trap.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int             XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(IF_RESET_PC),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(IF_NOP_INSTR)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_rd_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            cu_ready
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic            if_fault
`endif
);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;
  logic              pop, push, flush, issue, misalign;
  logic [2:0]        occ;
  logic [1:0]        count;
  logic [2*XLEN-1:0] head;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    squash_d   = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    issue      = 1'b0;
    pop        = if_valid & cu_ready;
    // Occupancy the buffer will have once this cycle's response and pop settle.
    occ        = 3'(count) + 3'(inflight_q) - 3'(pop);
`ifdef IF_MISALIGN_TRAP_EN
    misalign   = br_target[1:0] != 2'b00;
`else
    misalign   = 1'b0;
`endif
    if (br_taken) begin
      flush    = 1'b1;
      squash_d = inflight_q;
      if (misalign) begin
        state_d = FAULT;
      end else begin
        state_d = RUN;
        pc_d    = word_align(br_target);
      end
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN: begin
          push  = inflight_q & ~squash_q;
          issue = occ < 3'd2;
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
    if (issue) begin
      pc_d   = pc_q + XLEN'(4);
      addr_d = pc_q;
    end
    inflight_d = issue;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      squash_q   <= squash_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
  end

  fetch_buf #(.XLEN(XLEN)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({imem_rdata, addr_q}),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .count     (count)
  );

  assign imem_rd_en = issue;
  assign imem_addr  = pc_q;
  assign if_valid   = count != 2'd0;
  assign if_instr   = if_valid ? head[2*XLEN-1:XLEN] : NOP_INSTR;
  assign if_pc      = if_valid ? head[XLEN-1:0] : '0;
`ifdef IF_MISALIGN_TRAP_EN
  assign if_fault   = state_q == FAULT;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: main instance at RESET_PC=0x100 plus a second
// instance at RESET_PC=0xFFFF_FFF8 for PC wrap. Honours IF_MISALIGN_TRAP_EN.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_taken;
  logic [31:0] br_target;
  logic        cu_ready;

  logic        rd_en_a, valid_a;
  logic [31:0] addr_a, rdata_a = '0, instr_a, pc_a;
  logic        rd_en_b, valid_b;
  logic [31:0] addr_b, rdata_b = '0, instr_b, pc_b;
`ifdef IF_MISALIGN_TRAP_EN
  logic        fault_a, fault_b;
`endif

  int vectors = 0;
  int miscompares = 0;
  int n_issue;

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(32), .RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_rd_en (rd_en_a),
    .imem_addr  (addr_a),
    .imem_rdata (rdata_a),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .if_valid   (valid_a),
    .if_instr   (instr_a),
    .if_pc      (pc_a),
    .cu_ready   (cu_ready)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .if_fault   (fault_a)
`endif
  );

  instr_fetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0013)) dut_wrap (
    .clk        (clk),
    .reset      (reset),
    .imem_rd_en (rd_en_b),
    .imem_addr  (addr_b),
    .imem_rdata (rdata_b),
    .br_taken   (1'b0),
    .br_target  (32'h0),
    .if_valid   (valid_b),
    .if_instr   (instr_b),
    .if_pc      (pc_b),
    .cu_ready   (1'b1)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .if_fault   (fault_b)
`endif
  );

  // Instruction memories: word at address A reads back as A + 0xA000 one cycle later.
  always @(posedge clk) begin
    if (rd_en_a) rdata_a <= addr_a + 32'hA000;
    if (rd_en_b) rdata_b <= addr_b + 32'hA000;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic br, input logic [31:0] tgt, input logic rdy);
    @(posedge clk);
    #1;
    br_taken  = br;
    br_target = tgt;
    cu_ready  = rdy;
    #1;
  endtask

  initial begin
    reset = 1'b0; br_taken = 1'b0; br_target = '0; cu_ready = 1'b1;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    reset = 1'b1;
    #1;
    // R1: first cycle after release, still IDLE
    check_vec("rst_rd_en", 32'(rd_en_a), 32'd0);
    check_vec("rst_valid", 32'(valid_a), 32'd0);
    check_vec("rst_instr", instr_a, 32'h0000_0013);
    check_vec("rst_pc",    pc_a,    32'h0);
`ifdef IF_MISALIGN_TRAP_EN
    check_vec("rst_fault", 32'(fault_a), 32'd0);
`endif
    cyc(0, 0, 1); // R2
    check_vec("first_rd_en", 32'(rd_en_a), 32'd1);
    check_vec("first_addr",  addr_a, 32'h100);
    cyc(0, 0, 1); // R3
    check_vec("second_addr", addr_a, 32'h104);
    check_vec("r3_valid",    32'(valid_a), 32'd0);
    cyc(0, 0, 1); // R4
    check_vec("r4_valid", 32'(valid_a), 32'd1);
    check_vec("r4_pc",    pc_a,    32'h100);
    check_vec("r4_instr", instr_a, 32'hA100);
    check_vec("wrap_pc0", pc_b,    32'hFFFF_FFF8);
    cyc(0, 0, 1); // R5
    check_vec("r5_pc",    pc_a,    32'h104);
    check_vec("r5_instr", instr_a, 32'hA104);
    check_vec("wrap_pc1", pc_b,    32'hFFFF_FFFC);
    cyc(0, 0, 1); // R6
    check_vec("r6_pc",    pc_a, 32'h108);
    check_vec("wrap_pc2", pc_b, 32'h0000_0000);

    n_issue = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0);
      check_vec("stall_pc", pc_a, 32'h10C);
      n_issue += int'(rd_en_a);
    end
    check_vec("stall_issues_le2", 32'(n_issue <= 2), 32'd1);
    cyc(0, 0, 1); // R12
    check_vec("resume_pc0", pc_a, 32'h10C);
    cyc(0, 0, 1);
    check_vec("resume_pc1", pc_a, 32'h110);
    cyc(0, 0, 1);
    check_vec("resume_pc2", pc_a, 32'h114);
    cyc(0, 0, 1); // R15
    check_vec("resume_pc3", pc_a, 32'h118);

    cyc(1, 32'h40, 1); // R16: redirect with a read in flight
    check_vec("br_no_issue", 32'(rd_en_a), 32'd0);
    cyc(0, 0, 1);
    check_vec("br_tgt_rd_en", 32'(rd_en_a), 32'd1);
    check_vec("br_tgt_addr",  addr_a, 32'h40);
    check_vec("br_flushed",   32'(valid_a), 32'd0);
    cyc(0, 0, 1);
    check_vec("br_dropped", 32'(valid_a), 32'd0);
    cyc(0, 0, 1); // R19
    check_vec("br_tgt_pc",    pc_a,    32'h40);
    check_vec("br_tgt_instr", instr_a, 32'hA040);
    cyc(0, 0, 0); // R20: stall to fill the buffer
    check_vec("fill_pc", pc_a, 32'h44);
    cyc(1, 32'h200, 1); // R21: redirect coincident with pop on a full buffer
    check_vec("full_valid",    32'(valid_a), 32'd1);
    check_vec("full_no_issue", 32'(rd_en_a), 32'd0);
    cyc(0, 0, 1);
    check_vec("full_flushed", 32'(valid_a), 32'd0);
    check_vec("full_tgt_addr", addr_a, 32'h200);
    cyc(0, 0, 1);
    check_vec("full_empty2", 32'(valid_a), 32'd0);
    cyc(0, 0, 1);
    check_vec("full_tgt_pc0", pc_a, 32'h200);
    cyc(0, 0, 1);
    check_vec("full_tgt_pc1", pc_a, 32'h204);

    cyc(1, 32'h42, 1); // misaligned redirect
`ifdef IF_MISALIGN_TRAP_EN
    cyc(0, 0, 1);
    check_vec("mis_fault", 32'(fault_a), 32'd1);
    check_vec("mis_rd_en", 32'(rd_en_a), 32'd0);
    check_vec("mis_valid", 32'(valid_a), 32'd0);
    cyc(1, 32'h80, 1);
    check_vec("mis_hold_fault", 32'(fault_a), 32'd1);
    cyc(0, 0, 1);
    check_vec("clr_fault", 32'(fault_a), 32'd0);
    check_vec("clr_addr",  addr_a, 32'h80);
    check_vec("clr_rd_en", 32'(rd_en_a), 32'd1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check_vec("clr_pc", pc_a, 32'h80);
`else
    cyc(0, 0, 1);
    check_vec("mis_addr",  addr_a, 32'h40);
    check_vec("mis_rd_en", 32'(rd_en_a), 32'd1);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check_vec("mis_pc", pc_a, 32'h40);
`endif

    // Reset mid-stream while a read is outstanding
    cyc(0, 0, 1);
    reset = 1'b0;
    cyc(0, 0, 1);
    reset = 1'b1;
    #1;
    check_vec("mid_rst_valid", 32'(valid_a), 32'd0);
    check_vec("mid_rst_rd_en", 32'(rd_en_a), 32'd0);
    cyc(0, 0, 1);
    check_vec("mid_rst_valid2", 32'(valid_a), 32'd0);
    check_vec("mid_rst_addr",   addr_a, 32'h100);
    cyc(0, 0, 1);
    check_vec("mid_rst_valid3", 32'(valid_a), 32'd0);
    cyc(0, 0, 1);
    check_vec("mid_rst_pc", pc_a, 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
